// File: rtl/text_overlay_ctrl_if.sv
// Bundled descriptor-write, pixel, font-ROM and overlay-result signals of text_overlay_ctrl.
interface text_overlay_ctrl_if #(
  parameter int unsigned TEXT_BYTES = 10,
  parameter int unsigned SLOT_W     = 2
);
  logic                    frame_start;
  logic                    cfg_we;
  logic                    cfg_ready;
  logic [SLOT_W-1:0]       cfg_slot;
  logic [9:0]              cfg_x;
  logic [9:0]              cfg_y;
  logic [6:0]              cfg_len;
  logic [8*TEXT_BYTES-1:0] cfg_text;
  logic                    pix_valid;
  logic [9:0]              curr_x;
  logic [9:0]              curr_y;
  logic [10:0]             rom_adr;
  logic [7:0]              rom_data;
  logic                    pix_out_valid;
  logic                    pix_on;
  logic [SLOT_W-1:0]       pix_slot;

  // Overlay controller side
  modport slave (
    input  frame_start, cfg_we, cfg_slot, cfg_x, cfg_y, cfg_len, cfg_text,
    input  pix_valid, curr_x, curr_y, rom_data,
    output cfg_ready, rom_adr, pix_out_valid, pix_on, pix_slot
  );

  // Host / video-timing / font-ROM side
  modport master (
    output frame_start, cfg_we, cfg_slot, cfg_x, cfg_y, cfg_len, cfg_text,
    output pix_valid, curr_x, curr_y, rom_data,
    input  cfg_ready, rom_adr, pix_out_valid, pix_on, pix_slot
  );
endinterface

// File: rtl/text_overlay_ctrl.sv
// Text overlay scheduler: shares one registered 8x16 font ROM among SLOTS strings,
// with shadow descriptors committed atomically at frame start.
module text_overlay_ctrl #(
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned TEXT_BYTES = 10,
  parameter int unsigned SLOT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  text_overlay_ctrl_if.slave bus
);

  localparam int unsigned TEXT_W = 8 * TEXT_BYTES;

  // Active (displayed) and shadow (pending) descriptors
  logic [9:0]        r_act_x    [SLOTS];
  logic [9:0]        r_act_y    [SLOTS];
  logic [6:0]        r_act_len  [SLOTS];
  logic [TEXT_W-1:0] r_act_text [SLOTS];
  logic [9:0]        r_shd_x    [SLOTS];
  logic [9:0]        r_shd_y    [SLOTS];
  logic [6:0]        r_shd_len  [SLOTS];
  logic [TEXT_W-1:0] r_shd_text [SLOTS];
  logic [SLOTS-1:0]  r_pending;

  logic [SLOTS-1:0]  w_sel;
  logic              w_accept;
  logic [6:0]        w_len_clamp;

  // Pixel pipeline
  logic [SLOTS-1:0]  w_slot_hit;
  logic              w_hit;
  logic [SLOT_W-1:0] w_slot;
  logic [9:0]        w_d;
  logic [3:0]        w_dy;
  logic [6:0]        w_len;
  logic [TEXT_W-1:0] w_text;
  logic [6:0]        w_byte;
  logic [7:0]        w_char;
  logic              w_char_msb_unused;
  logic              w_on;

  logic [10:0]       r_rom_adr;
  logic [2:0]        r_col0;
  logic              r_hit0;
  logic [SLOT_W-1:0] r_slot0;
  logic              r_valid0;
  logic [2:0]        r_col1;
  logic              r_hit1;
  logic [SLOT_W-1:0] r_slot1;
  logic              r_valid1;

  // One-hot decode of the target slot; out-of-range indices decode to nothing
  always_comb begin
    w_sel = '0;
    for (int s = 0; s < int'(SLOTS); s++) begin
      if (bus.cfg_slot == SLOT_W'(s)) w_sel[s] = 1'b1;
    end
  end

  assign bus.cfg_ready = ~rst & (|(w_sel & ~r_pending));
  assign w_accept      = bus.cfg_we & bus.cfg_ready;
  assign w_len_clamp   = (bus.cfg_len > 7'(TEXT_BYTES)) ? 7'(TEXT_BYTES) : bus.cfg_len;

  // Shadow writes and frame-start commit; a write accepted alongside frame_start stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      for (int s = 0; s < int'(SLOTS); s++) begin
        r_act_x[s]    <= '0;
        r_act_y[s]    <= '0;
        r_act_len[s]  <= '0;
        r_act_text[s] <= '0;
        r_shd_x[s]    <= '0;
        r_shd_y[s]    <= '0;
        r_shd_len[s]  <= '0;
        r_shd_text[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(SLOTS); s++) begin
        if (bus.frame_start && r_pending[s]) begin
          r_act_x[s]    <= r_shd_x[s];
          r_act_y[s]    <= r_shd_y[s];
          r_act_len[s]  <= r_shd_len[s];
          r_act_text[s] <= r_shd_text[s];
          r_pending[s]  <= 1'b0;
        end
        if (w_accept && w_sel[s]) begin
          r_shd_x[s]    <= bus.cfg_x;
          r_shd_y[s]    <= bus.cfg_y;
          r_shd_len[s]  <= w_len_clamp;
          r_shd_text[s] <= bus.cfg_text;
          r_pending[s]  <= 1'b1;
        end
      end
    end
  end

  // Per-slot coverage test, 11-bit compares so right/bottom edges clip instead of wrapping
  always_comb begin
    w_slot_hit = '0;
    for (int s = 0; s < int'(SLOTS); s++) begin
      w_slot_hit[s] = (r_act_len[s] != 7'd0) &&
                      (bus.curr_x >= r_act_x[s]) &&
                      ({1'b0, bus.curr_x} < ({1'b0, r_act_x[s]} + {1'b0, r_act_len[s], 3'b000})) &&
                      (bus.curr_y >= r_act_y[s]) &&
                      ({1'b0, bus.curr_y} < ({1'b0, r_act_y[s]} + 11'd16));
    end
  end

  // Priority pick: walk from the highest index down so the lowest hitting slot wins
  always_comb begin
    w_hit  = 1'b0;
    w_slot = '0;
    w_d    = '0;
    w_dy   = '0;
    w_len  = '0;
    w_text = '0;
    for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
      if (w_slot_hit[s]) begin
        w_hit  = 1'b1;
        w_slot = SLOT_W'(s);
        w_d    = bus.curr_x - r_act_x[s];
        w_dy   = bus.curr_y[3:0] - r_act_y[s][3:0];
        w_len  = r_act_len[s];
        w_text = r_act_text[s];
      end
    end
  end

  // Character fetch: first character sits in the top byte of the used range
  always_comb begin
    w_byte = w_len - 7'd1 - w_d[9:3];
    w_char = '0;
    for (int b = 0; b < int'(TEXT_BYTES); b++) begin
      if (w_byte == 7'(b)) w_char = w_text[8*b +: 8];
    end
  end

  // Glyph codes are 7-bit; the top character bit is deliberately dropped
  assign w_char_msb_unused = w_char[7];

  // Stage 0 register: ROM address holds on misses, side-band follows every pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_adr <= '0;
      r_col0    <= '0;
      r_hit0    <= 1'b0;
      r_slot0   <= '0;
      r_valid0  <= 1'b0;
    end else begin
      r_valid0 <= bus.pix_valid;
      r_hit0   <= bus.pix_valid & w_hit;
      r_slot0  <= w_slot;
      r_col0   <= w_d[2:0];
      if (bus.pix_valid && w_hit) r_rom_adr <= {w_char[6:0], w_dy};
    end
  end

  // Stage 1 register: side-band waits alongside the ROM access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col1   <= '0;
      r_hit1   <= 1'b0;
      r_slot1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_col1   <= r_col0;
      r_hit1   <= r_hit0;
      r_slot1  <= r_slot0;
      r_valid1 <= r_valid0;
    end
  end

  // Stage 2: pick the glyph bit (bit 7 is leftmost, so index is ~col)
  assign w_on              = r_valid1 & r_hit1 & bus.rom_data[~r_col1];
  assign bus.rom_adr       = r_rom_adr;
  assign bus.pix_out_valid = r_valid1;
  assign bus.pix_on        = w_on;
  assign bus.pix_slot      = w_on ? r_slot1 : '0;

endmodule
